// File: rtl/counter_b4_pkg.sv
// Shared constants for the 4-bit counter event monitor: event types, counter
// mode encodings, record layout and the expected-step helper.
package counter_b4_pkg;

    localparam int REC_W    = 8;
    localparam int TYPE_LSB = 6;
    localparam int MODE_LSB = 4;
    localparam int Q_LSB    = 0;

    localparam logic [1:0] EVT_LOAD = 2'b00;
    localparam logic [1:0] EVT_WRAP = 2'b01;
    localparam logic [1:0] EVT_ERR  = 2'b10;

    localparam logic [1:0] MODE_UP3  = 2'b00;
    localparam logic [1:0] MODE_DN1  = 2'b01;
    localparam logic [1:0] MODE_UP1  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    // Value the counter should reach one step after q in the given counting mode.
    function automatic logic [3:0] step_q(input logic [3:0] q, input logic [1:0] mode);
        logic [3:0] r;
        case (mode)
            MODE_UP3: r = q + 4'd3;
            MODE_DN1: r = q - 4'd1;
            MODE_UP1: r = q + 4'd1;
            default:  r = q;
        endcase
        return r;
    endfunction

    function automatic logic [REC_W-1:0] make_rec(input logic [1:0] typ,
                                                  input logic [1:0] mode,
                                                  input logic [3:0] q);
        return {typ, mode, q};
    endfunction

endpackage

// File: rtl/counter_b4_evt_fifo.sv
// Show-ahead synchronous FIFO for event records; accepts a push on the same
// cycle as a pop even when full.
module counter_b4_evt_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
    logic [AW:0]      level_reg, level_next;
    logic [WIDTH-1:0] dout_reg;
    logic             push_ok, pop_ok;

    assign empty   = (level_reg == '0);
    assign full    = (level_reg == (AW+1)'(DEPTH));
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        if (push_ok) wr_ptr_next = wr_ptr_reg + AW'(1);
        if (pop_ok)  rd_ptr_next = rd_ptr_reg + AW'(1);
        level_next = level_reg + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_reg] <= din;
    end

    // Registered head: bypass the incoming word when it lands in the head slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
            dout_reg   <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            level_reg  <= level_next;
            if (level_next != '0) begin
                if (push_ok && (rd_ptr_next == wr_ptr_reg))
                    dout_reg <= din;
                else
                    dout_reg <= mem[rd_ptr_next];
            end
        end
    end

    assign dout  = dout_reg;
    assign level = level_reg;

endmodule

// File: rtl/counter_b4_event_mon.sv
// Monitor for the 4-bit up/down/load counter: wrap counting and load/wrap/step-error
// records buffered toward a valid/ready consumer. Step checking: COUNTER_B4_MON_CHECK_EN.
module counter_b4_event_mon
    import counter_b4_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int WRAP_W     = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [1:0]                    mode,
    input  logic [3:0]                    Q,
    input  logic                          rco,
    input  logic                          load,
    output logic                          evt_valid,
    output logic [REC_W-1:0]              evt_data,
    input  logic                          evt_ready,
    output logic [WRAP_W-1:0]             wrap_count,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic [3:0]                    err_count
);
    localparam logic [WRAP_W-1:0] WRAP_ONE = 1;

    logic              step_err;
    logic              evt_exists;
    logic [1:0]        evt_type;
    logic [REC_W-1:0]  evt_rec;
    logic              fifo_empty, fifo_full;
    logic [WRAP_W-1:0] wrap_count_reg;
    logic              overflow_reg;

`ifdef COUNTER_B4_MON_CHECK_EN
    logic       prev_valid_reg;
    logic [3:0] prev_q_reg;
    logic [1:0] prev_mode_reg;
    logic [3:0] err_count_reg;

    // A load-mode step without the load strobe can never be legal.
    assign step_err = enable && prev_valid_reg && !load &&
                      ((prev_mode_reg == MODE_LOAD) || (Q != step_q(prev_q_reg, prev_mode_reg)));

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_valid_reg <= 1'b0;
            prev_q_reg     <= '0;
            prev_mode_reg  <= '0;
            err_count_reg  <= '0;
        end else if (enable) begin
            prev_valid_reg <= 1'b1;
            prev_q_reg     <= Q;
            prev_mode_reg  <= mode;
            if (step_err && (err_count_reg != 4'hF))
                err_count_reg <= err_count_reg + 4'd1;
        end
    end

    assign err_count = err_count_reg;
`else
    assign step_err  = 1'b0;
    assign err_count = '0;
`endif

    assign evt_exists = enable && (load || rco || step_err);
    assign evt_type   = load ? EVT_LOAD : (rco ? EVT_WRAP : EVT_ERR);
    assign evt_rec    = make_rec(evt_type, mode, Q);

    counter_b4_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (REC_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (evt_exists),
        .din   (evt_rec),
        .pop   (evt_ready),
        .dout  (evt_data),
        .empty (fifo_empty),
        .full  (fifo_full),
        .level (fifo_level)
    );

    // When full, any pop request is honoured, so only an idle consumer drops a record.
    always_ff @(posedge clk) begin
        if (reset) begin
            wrap_count_reg <= '0;
            overflow_reg   <= 1'b0;
        end else begin
            if (enable && rco && (wrap_count_reg != {WRAP_W{1'b1}}))
                wrap_count_reg <= wrap_count_reg + WRAP_ONE;
            if (evt_exists && fifo_full && !evt_ready)
                overflow_reg <= 1'b1;
        end
    end

    assign evt_valid  = !fifo_empty;
    assign wrap_count = wrap_count_reg;
    assign overflow   = overflow_reg;

endmodule

// File: tb/tb_counter_b4_event_mon.sv
// Directed bench for counter_b4_event_mon with a queue-based reference model.
module tb_counter_b4_event_mon;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [1:0] mode;
    logic [3:0] q_in;
    logic       rco;
    logic       load;
    logic       evt_ready;
    logic       evt_valid;
    logic [7:0] evt_data;
    logic [7:0] wrap_count;
    logic [2:0] fifo_level;
    logic       overflow;
    logic [3:0] err_count;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Reference model state
    logic [7:0] m_q[$];
    logic [7:0] m_last;
    int         m_wrap;
    int         m_err;
    bit         m_ovf;
    bit         m_prev_valid;
    int         m_prev_q;
    int         m_prev_mode;

    always #5 clk = ~clk;

    counter_b4_event_mon #(
        .FIFO_DEPTH (DEPTH),
        .WRAP_W     (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .mode       (mode),
        .Q          (q_in),
        .rco        (rco),
        .load       (load),
        .evt_valid  (evt_valid),
        .evt_data   (evt_data),
        .evt_ready  (evt_ready),
        .wrap_count (wrap_count),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .err_count  (err_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        bit pop;
        bit err;
        int exp_q;
        if (reset) begin
            m_q.delete();
            m_last = 8'h00;
            m_wrap = 0;
            m_err = 0;
            m_ovf = 1'b0;
            m_prev_valid = 1'b0;
            m_prev_q = 0;
            m_prev_mode = 0;
            return;
        end
        pop = evt_ready && (m_q.size() > 0);
        if (pop) void'(m_q.pop_front());
        if (enable) begin
            err = 1'b0;
`ifdef COUNTER_B4_MON_CHECK_EN
            if (m_prev_valid && !load) begin
                if (m_prev_mode == 3) err = 1'b1;
                else begin
                    exp_q = (m_prev_q + (m_prev_mode == 0 ? 3 : (m_prev_mode == 1 ? 15 : 1))) % 16;
                    err = (exp_q != int'(q_in));
                end
            end
            if (err && m_err < 15) m_err++;
            m_prev_valid = 1'b1;
            m_prev_q = int'(q_in);
            m_prev_mode = int'(mode);
`else
            exp_q = 0;
`endif
            if (rco && m_wrap < 255) m_wrap++;
            if (load || rco || err) begin
                if (m_q.size() < DEPTH)
                    m_q.push_back({(load ? 2'b00 : (rco ? 2'b01 : 2'b10)), mode, q_in});
                else
                    m_ovf = 1'b1;
            end
        end
        if (m_q.size() > 0) m_last = m_q[0];
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("evt_valid", 32'(evt_valid), 32'(m_q.size() > 0));
            chk("evt_data", 32'(evt_data), 32'(m_last));
            chk("wrap_count", 32'(wrap_count), 32'(m_wrap));
            chk("fifo_level", 32'(fifo_level), 32'(m_q.size()));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("err_count", 32'(err_count), 32'(m_err));
            $display("cyc t=%0t rst=%0b en=%0b mode=%0d Q=%0h rco=%0b ld=%0b rdy=%0b -> v=%0b d=%02h lvl=%0d wrap=%0d ovf=%0b err=%0d",
                     $time, reset, enable, mode, q_in, rco, load, evt_ready,
                     evt_valid, evt_data, fifo_level, wrap_count, overflow, err_count);
        end
    end

    task automatic cyc(input bit en, input logic [1:0] md, input logic [3:0] q,
                       input bit r, input bit ld, input bit rdy);
        reset = 1'b0; enable = en; mode = md; q_in = q; rco = r; load = ld; evt_ready = rdy;
        @(posedge clk);
        model_update();
        cmp_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic rst_cyc(input int n);
        for (int i = 0; i < n; i++) begin
            reset = 1'b1; enable = 1'b0; rco = 1'b0; load = 1'b0; evt_ready = 1'b0;
            @(posedge clk);
            model_update();
            cmp_en = 1'b1;
            @(negedge clk);
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; mode = 2'b00; q_in = 4'h0;
        rco = 1'b0; load = 1'b0; evt_ready = 1'b0;

        // Reset, then count up by one through a wrap
        rst_cyc(3);
        chk("rst_valid", 32'(evt_valid), 32'd0);
        chk("rst_data", 32'(evt_data), 32'h00);
        for (int i = 0; i < 16; i++) cyc(1'b1, 2'b10, 4'(i), i == 15, 1'b0, 1'b0);
        chk("wrap_rec", 32'(evt_data), 32'h6F);
        chk("wrap_lvl", 32'(fifo_level), 32'd1);
        chk("wrap_cnt", 32'(wrap_count), 32'd1);
        chk("wrap_err", 32'(err_count), 32'd0);
        cyc(1'b0, 2'b10, 4'h0, 1'b0, 1'b0, 1'b1);
        chk("drain1_lvl", 32'(fifo_level), 32'd0);

        // Load wins over wrap, wrap still counted
        rst_cyc(1);
        cyc(1'b1, 2'b11, 4'hA, 1'b1, 1'b1, 1'b0);
        chk("load_rec", 32'(evt_data), 32'h3A);
        chk("load_wrap", 32'(wrap_count), 32'd1);
        cyc(1'b0, 2'b11, 4'hA, 1'b0, 1'b0, 1'b1);

        // Overflow with stalled consumer, then in-order drain
        rst_cyc(1);
        for (int i = 1; i <= 5; i++) cyc(1'b1, 2'b10, 4'(i), 1'b1, 1'b0, 1'b0);
        chk("ovf_lvl", 32'(fifo_level), 32'd4);
        chk("ovf_flag", 32'(overflow), 32'd1);
        for (int k = 0; k < 4; k++) begin
            chk("drain_head", 32'(evt_data), 32'(8'h61 + k));
            cyc(1'b0, 2'b10, 4'h0, 1'b0, 1'b0, 1'b1);
        end
        chk("drain_lvl", 32'(fifo_level), 32'd0);
        chk("drain_valid", 32'(evt_valid), 32'd0);
        chk("ovf_wrap", 32'(wrap_count), 32'd5);

        // Full FIFO: simultaneous push and pop
        rst_cyc(1);
        for (int i = 1; i <= 4; i++) cyc(1'b1, 2'b10, 4'(i), 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 2'b10, 4'h5, 1'b1, 1'b0, 1'b1);
        chk("pp_lvl", 32'(fifo_level), 32'd4);
        chk("pp_ovf", 32'(overflow), 32'd0);
        chk("pp_head", 32'(evt_data), 32'h62);

        // Reset with records queued; first sample afterwards is not step-checked
        cyc(1'b0, 2'b10, 4'h0, 1'b0, 1'b0, 1'b1);
        chk("q3_lvl", 32'(fifo_level), 32'd3);
        rst_cyc(1);
        chk("mid_valid", 32'(evt_valid), 32'd0);
        chk("mid_lvl", 32'(fifo_level), 32'd0);
        chk("mid_wrap", 32'(wrap_count), 32'd0);
        chk("mid_ovf", 32'(overflow), 32'd0);
        cyc(1'b1, 2'b00, 4'h9, 1'b0, 1'b0, 1'b0);
        chk("post_rst_err", 32'(err_count), 32'd0);
        chk("post_rst_lvl", 32'(fifo_level), 32'd0);

        // Step +3 sequence 0 -> 3 -> 7
        rst_cyc(1);
        cyc(1'b1, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 2'b00, 4'h3, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 2'b00, 4'h7, 1'b0, 1'b0, 1'b0);
`ifdef COUNTER_B4_MON_CHECK_EN
        chk("step_lvl", 32'(fifo_level), 32'd1);
        chk("step_rec", 32'(evt_data), 32'h87);
        chk("step_err", 32'(err_count), 32'd1);
`else
        chk("step_lvl", 32'(fifo_level), 32'd0);
        chk("step_err", 32'(err_count), 32'd0);
`endif

        // Legal down-count, then load mode followed by a non-load step
        rst_cyc(1);
        cyc(1'b1, 2'b01, 4'h5, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 2'b01, 4'h4, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 2'b01, 4'hC, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 2'b01, 4'h3, 1'b0, 1'b0, 1'b0);
        chk("dn_lvl", 32'(fifo_level), 32'd0);
        cyc(1'b1, 2'b11, 4'h2, 1'b0, 1'b1, 1'b0);
        chk("ld_rec", 32'(evt_data), 32'h32);
        cyc(1'b1, 2'b01, 4'h5, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 2'b01, 4'h0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 2'b01, 4'h0, 1'b0, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
